// File: rtl/sis_vector_loader.sv
// sis_vector_loader
// Assembles one transform input vector of runtime length N (4/8/16/32) from
// residual samples arriving LANES per beat. It is ping-pong buffered so a new
// vector can be loaded while the previous one waits for the consumer.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     input beat handshake
//   in_data               LANES samples, lane j at [j*WIDTH +: WIDTH], lane 0 = lowest index
//   in_size, in_type      size code (0=4,1=8,2=16,3=32) and transform type, taken on first beat
//   out_valid/out_ready   assembled vector handshake
//   out_vector            32-entry vector, entries at or above N read as zero
//   out_type, out_size    metadata latched with the vector
//
// Handshake: a transfer happens on a rising edge where valid && ready. in_ready
// and out_valid are driven only from registers (plus rst for in_ready), never
// from in_valid or out_ready. The consumer-side payload stays stable while
// out_valid is high and out_ready is low.
module sis_vector_loader #(
  parameter int WIDTH = 16,
  parameter int MAX_N = 32,
  parameter int LANES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WIDTH-1:0]        in_data,
  input  logic [1:0]                    in_size,
  input  logic [1:0]                    in_type,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WIDTH-1:0]       out_vector [MAX_N-1:0],
  output logic [1:0]                    out_type,
  output logic [1:0]                    out_size
);

  logic signed [WIDTH-1:0] mem [2][MAX_N];
  logic [1:0]              size_q [2];
  logic [1:0]              type_q [2];
  logic [1:0]              full;
  logic                    wr_sel;
  logic                    rd_sel;
  logic [5:0]              beat_cnt;

  logic                    in_acc;
  logic                    out_acc;
  logic                    last_beat;
  logic [1:0]              eff_size;
  logic [5:0]              n_elems;
  logic [5:0]              beats;
  logic [4:0]              base_idx;
  logic [5:0]              rd_n;

  assign in_ready  = !rst && !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  // On the first beat the size is not yet stored, so the beat count comes from
  // the live input; afterwards it comes from the latched metadata so that a
  // size change mid-vector cannot alter the vector length.
  always_comb begin
    eff_size  = (beat_cnt == 6'd0) ? in_size : size_q[wr_sel];
    n_elems   = 6'd4 << eff_size;
    beats     = n_elems / 6'(LANES);
    last_beat = (beat_cnt == beats - 6'd1);
    base_idx  = 5'(beat_cnt * 6'(LANES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < MAX_N; i++) begin
          mem[b][i] <= '0;
        end
        size_q[b] <= '0;
        type_q[b] <= '0;
      end
      full     <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (in_acc) begin
        for (int j = 0; j < LANES; j++) begin
          mem[wr_sel][base_idx + 5'(j)] <= in_data[j*WIDTH +: WIDTH];
        end
        if (beat_cnt == 6'd0) begin
          size_q[wr_sel] <= in_size;
          type_q[wr_sel] <= in_type;
        end
        if (last_beat) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
          beat_cnt     <= '0;
        end else begin
          beat_cnt <= beat_cnt + 6'd1;
        end
      end
      // in_acc needs full[wr_sel]==0 and out_acc needs full[rd_sel]==1, so the
      // two updates never target the same flag in one cycle.
      if (out_acc) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

  // Entries beyond N are masked on read, so data left over from an earlier,
  // longer vector in the same buffer never reaches the consumer.
  always_comb begin
    rd_n     = 6'd4 << size_q[rd_sel];
    out_type = type_q[rd_sel];
    out_size = size_q[rd_sel];
    for (int i = 0; i < MAX_N; i++) begin
      out_vector[i] = (6'(i) < rd_n) ? mem[rd_sel][i] : '0;
    end
  end

endmodule

// File: tb/tb_sis_vector_loader.sv
module tb_sis_vector_loader;
  localparam int WIDTH = 16;
  localparam int MAX_N = 32;
  localparam int LANES = 4;
  localparam int VEC_W = MAX_N*WIDTH + 4;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*WIDTH-1:0]  in_data;
  logic [1:0]              in_size;
  logic [1:0]              in_type;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_vector [MAX_N-1:0];
  logic [1:0]              out_type;
  logic [1:0]              out_size;

  sis_vector_loader #(.WIDTH(WIDTH), .MAX_N(MAX_N), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_size(in_size), .in_type(in_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vector(out_vector), .out_type(out_type), .out_size(out_size)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: each entry is {type, size, 32 elements}, element i at [i*WIDTH +: WIDTH]
  logic [VEC_W-1:0]      exp_q[$];
  logic [MAX_N*WIDTH-1:0] cur_vec;
  logic [1:0]            cur_sz;
  logic [1:0]            cur_ty;
  int                    cur_cnt;
  int                    err_cnt;
  int                    chk_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: elements are gathered in arrival order; a vector is complete
  // once 4<<size elements (size from its first beat) have arrived.
  task automatic model_beat(input logic [LANES*WIDTH-1:0] data, input logic [1:0] sz,
                            input logic [1:0] ty);
    if (cur_cnt == 0) begin
      cur_vec = '0;
      cur_sz  = sz;
      cur_ty  = ty;
    end
    for (int j = 0; j < LANES; j++) begin
      cur_vec[(cur_cnt + j)*WIDTH +: WIDTH] = data[j*WIDTH +: WIDTH];
    end
    cur_cnt += LANES;
    if (cur_cnt == (4 << cur_sz)) begin
      exp_q.push_back({cur_ty, cur_sz, cur_vec});
      cur_cnt = 0;
    end
  endtask

  task automatic check_outputs_zero();
    logic [WIDTH-1:0] o;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_type", 32'(out_type), 32'(0));
    check("rst_out_size", 32'(out_size), 32'(0));
    for (int i = 0; i < MAX_N; i++) begin
      o = out_vector[i];
      check($sformatf("rst_elem%0d", i), 32'(o), 32'(0));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check_outputs_zero();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cur_cnt = 0;
  endtask

  // One cycle: drive inputs at negedge, check outputs against the model, then
  // advance the model by what the model says was accepted.
  task automatic drive_cycle(input logic vld, input logic [LANES*WIDTH-1:0] data,
                             input logic [1:0] sz, input logic [1:0] ty,
                             input logic ordy, output logic accepted);
    logic             exp_ready;
    logic             exp_valid;
    logic [VEC_W-1:0] head;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] e;
    @(negedge clk);
    in_valid  = vld;
    in_data   = data;
    in_size   = sz;
    in_type   = ty;
    out_ready = ordy;
    #1;
    exp_ready = (exp_q.size() < 2);
    exp_valid = (exp_q.size() > 0);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      head = exp_q[0];
      check("out_type", 32'(out_type), 32'(head[VEC_W-1 -: 2]));
      check("out_size", 32'(out_size), 32'(head[VEC_W-3 -: 2]));
      for (int i = 0; i < MAX_N; i++) begin
        o = out_vector[i];
        e = head[i*WIDTH +: WIDTH];
        check($sformatf("elem%0d", i), 32'(o), 32'(e));
      end
      if (ordy) void'(exp_q.pop_front());
    end
    accepted = vld && exp_ready;
    if (accepted) model_beat(data, sz, ty);
  endtask

  // Holds a beat valid until accepted, with a cycle bound.
  task automatic send_beat(input logic [LANES*WIDTH-1:0] data, input logic [1:0] sz,
                           input logic [1:0] ty, input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      drive_cycle(1'b1, data, sz, ty, ordy, acc);
      n++;
    end
    if (!acc) check("beat_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, 2'd0, 2'd0, ordy, acc);
  endtask

  function automatic logic [LANES*WIDTH-1:0] mk4(input int a, input int b, input int c, input int d);
    logic [WIDTH-1:0] la, lb, lc, ld;
    la = WIDTH'(a); lb = WIDTH'(b); lc = WIDTH'(c); ld = WIDTH'(d);
    return {ld, lc, lb, la};
  endfunction

  function automatic logic [LANES*WIDTH-1:0] rand_data();
    logic [LANES*WIDTH-1:0] d;
    for (int j = 0; j < LANES; j++) d[j*WIDTH +: WIDTH] = WIDTH'($urandom);
    return d;
  endfunction

  // Random traffic: a pending beat is held until accepted; size and type are
  // re-randomized every beat, so later beats present different metadata.
  task automatic random_phase(input int cycles, input int p_vld, input int p_rdy,
                              input int size_lo, input int size_hi);
    logic                   acc;
    logic                   pend;
    logic [LANES*WIDTH-1:0] d;
    logic [1:0]             sz;
    logic [1:0]             ty;
    logic                   rdy;
    pend = 1'b0;
    d = '0; sz = '0; ty = '0;
    for (int k = 0; k < cycles; k++) begin
      if (!pend) begin
        pend = ($urandom_range(99, 0) < p_vld);
        d    = rand_data();
        sz   = 2'($urandom_range(size_hi, size_lo));
        ty   = 2'($urandom_range(3, 0));
      end
      rdy = ($urandom_range(99, 0) < p_rdy);
      drive_cycle(pend, d, sz, ty, rdy, acc);
      if (acc) pend = 1'b0;
    end
    // A beat offered but not taken is withdrawn only at the end of the phase.
  endtask

  initial begin
    logic [LANES*WIDTH-1:0] d;
    err_cnt = 0;
    chk_cnt = 0;
    cur_cnt = 0;
    cur_vec = '0;
    cur_sz  = '0;
    cur_ty  = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_size = '0;
    in_type = '0;
    out_ready = 1'b0;
    do_reset();

    // single-beat N=4 vector
    send_beat(mk4(1, 2, 3, 4), 2'd0, 2'd0, 1'b1);
    idle(2, 1'b1);

    // N=32, values 0..31, then an N=4 vector with -1 in lane 0
    for (int b = 0; b < 8; b++) send_beat(mk4(4*b, 4*b+1, 4*b+2, 4*b+3), 2'd3, 2'd2, 1'b1);
    send_beat(mk4(-1, 5, -7, 32767), 2'd0, 2'd3, 1'b1);
    idle(2, 1'b1);

    // backpressure: three N=8 vectors offered with the consumer stalled
    for (int b = 0; b < 4; b++) send_beat(mk4(10+b, 20+b, 30+b, 40+b), 2'd1, 2'd1, 1'b0);
    idle(3, 1'b0);
    d = mk4(7, 7, 7, 7);
    begin
      logic acc;
      drive_cycle(1'b1, d, 2'd1, 2'd1, 1'b0, acc);
      drive_cycle(1'b1, d, 2'd1, 2'd1, 1'b0, acc);
    end
    send_beat(d, 2'd1, 2'd1, 1'b1);
    send_beat(mk4(8, 8, 8, 8), 2'd1, 2'd1, 1'b1);
    idle(3, 1'b1);

    // mid-vector size change: first beat size 3, later beats size 0
    send_beat(rand_data(), 2'd3, 2'd0, 1'b1);
    for (int b = 1; b < 8; b++) send_beat(rand_data(), 2'd0, 2'd1, 1'b1);
    idle(2, 1'b1);

    // continuous N=16 stream, consumer always ready
    random_phase(40, 100, 100, 2, 2);
    idle(3, 1'b1);

    // mixed random traffic
    random_phase(400, 70, 60, 0, 3);
    random_phase(300, 100, 20, 0, 3);
    random_phase(300, 50, 100, 0, 1);
    idle(6, 1'b1);

    // reset in the middle of an N=32 vector, then a fresh N=4 vector
    for (int b = 0; b < 3; b++) send_beat(mk4(100+b, 200+b, 300+b, 400+b), 2'd3, 2'd2, 1'b1);
    do_reset();
    send_beat(mk4(9, 8, 7, 6), 2'd0, 2'd0, 1'b1);
    idle(3, 1'b1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
